// File: rtl/icache_pkg.sv
// Shared types, sizes and address-field helpers for the instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_READ,
        S_UPDATE
    } state_t;

    localparam int OFFSET_BITS = 2;
    localparam int BLOCK_WORDS = 4;
    localparam int BLOCK_WIDTH = 128;

    function automatic logic [OFFSET_BITS-1:0] get_offset(input logic [31:0] pc);
        return OFFSET_BITS'(pc >> 2);
    endfunction

    function automatic logic [31:0] get_index(input logic [31:0] pc, input int ib);
        return (pc >> 4) & ((32'd1 << ib) - 32'd1);
    endfunction

    function automatic logic [31:0] get_tag(input logic [31:0] pc, input int ib, input int tb);
        return (pc >> (4 + ib)) & ((32'd1 << tb) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read port, synchronous write port.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [INDEX_BITS-1:0]  rd_index,
    output logic                   rd_valid,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic [BLOCK_WIDTH-1:0] rd_block,
    input  logic                   we,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [TAG_BITS-1:0]    wr_tag,
    input  logic [BLOCK_WIDTH-1:0] wr_block
);

    localparam int NUM_BLOCKS = 1 << INDEX_BITS;

    logic [NUM_BLOCKS-1:0]  valid;
    logic [TAG_BITS-1:0]    tag_mem  [NUM_BLOCKS];
    logic [BLOCK_WIDTH-1:0] data_mem [NUM_BLOCKS];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_block = data_mem[rd_index];

    always_ff @(posedge CLK) begin
        if (RESET)
            valid <= '0;
        else if (we)
            valid[wr_index] <= 1'b1;
    end

    // Reset aborts a pending write so no half-refilled block survives.
    always_ff @(posedge CLK) begin
        if (we && !RESET) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_block;
        end
    end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache; refills 16-byte blocks over a
// 128-bit port and stalls fetch via BUSYWAIT on a miss.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 3
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [31:0]                  PC,
    output logic [31:0]                  INSTRUCTION,
    output logic                         BUSYWAIT,
    output logic                         MEM_READ,
    output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
    input  logic [BLOCK_WIDTH-1:0]       MEM_READDATA,
    input  logic                         MEM_BUSYWAIT
);

    state_t                         state;
    logic [TAG_BITS+INDEX_BITS-1:0] miss_addr;
    logic [BLOCK_WIDTH-1:0]         refill_buf;

    logic [INDEX_BITS-1:0]  pc_index;
    logic [TAG_BITS-1:0]    pc_tag;
    logic [OFFSET_BITS-1:0] pc_offset;

    logic                   rd_valid;
    logic [TAG_BITS-1:0]    rd_tag;
    logic [BLOCK_WIDTH-1:0] rd_block;
    logic                   hit;

    assign pc_index  = INDEX_BITS'(get_index(PC, INDEX_BITS));
    assign pc_tag    = TAG_BITS'(get_tag(PC, INDEX_BITS, TAG_BITS));
    assign pc_offset = get_offset(PC);

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .CLK      (CLK),
        .RESET    (RESET),
        .rd_index (pc_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_block (rd_block),
        .we       (state == S_UPDATE),
        .wr_index (miss_addr[INDEX_BITS-1:0]),
        .wr_tag   (miss_addr[TAG_BITS+INDEX_BITS-1:INDEX_BITS]),
        .wr_block (refill_buf)
    );

    assign hit         = rd_valid && (rd_tag == pc_tag);
    assign INSTRUCTION = rd_block[{pc_offset, 5'b0} +: 32];
    assign BUSYWAIT    = !RESET && ((state != S_IDLE) || !hit);
    assign MEM_ADDRESS = miss_addr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            MEM_READ   <= 1'b0;
            miss_addr  <= '0;
            refill_buf <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!hit) begin
                        miss_addr <= {pc_tag, pc_index};
                        MEM_READ  <= 1'b1;
                        state     <= S_MEM_READ;
                    end
                end
                S_MEM_READ: begin
                    if (!MEM_BUSYWAIT) begin
                        refill_buf <= MEM_READDATA;
                        MEM_READ   <= 1'b0;
                        state      <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    state <= S_IDLE;
                end
                default: begin
                    MEM_READ <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
